// File: rtl/data_mem_responder_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_responder_pkg
// Shared constants for the data-memory responder: I/O page base and register
// offsets, STATUS bit layout, RAM region tag and the address decode helper.
// -----------------------------------------------------------------------------
package data_mem_responder_pkg;

    localparam logic [31:0] IO_BASE    = 32'hFFFF_0000;
    localparam logic [3:0]  OFF_TXDATA = 4'h0;
    localparam logic [3:0]  OFF_STATUS = 4'h4;
    localparam logic [3:0]  OFF_TIMER  = 4'h8;
    localparam logic [3:0]  OFF_CMP    = 4'hC;

    localparam int STATUS_FULL      = 0;
    localparam int STATUS_EMPTY     = 1;
    localparam int STATUS_MATCH     = 2;
    localparam int STATUS_OVF       = 3;
    localparam int STATUS_COUNT_LSB = 4;
    localparam int STATUS_COUNT_W   = 5;

    // addr[31:28] value selecting the RAM region
    localparam logic [3:0] RAM_REGION = 4'h0;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_RAM,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_TIMER,
        SEL_CMP
    } sel_e;

    // Word-address decode; the byte offset bits never take part.
    function automatic sel_e decode_addr(input logic [31:2] a);
        sel_e s;
        s = SEL_NONE;
        if (a[31:28] == RAM_REGION) begin
            s = SEL_RAM;
        end else if (a[31:4] == IO_BASE[31:4]) begin
            case ({a[3:2], 2'b00})
                OFF_TXDATA: s = SEL_TXDATA;
                OFF_STATUS: s = SEL_STATUS;
                OFF_TIMER:  s = SEL_TIMER;
                OFF_CMP:    s = SEL_CMP;
                default:    s = SEL_NONE;
            endcase
        end
        return s;
    endfunction

endpackage

// File: rtl/data_mem_responder_tx_fifo.sv
// -----------------------------------------------------------------------------
// tx_byte_fifo
// Byte FIFO behind the TXDATA register. A push into a full FIFO is still
// accepted when a pop frees the head slot in the same cycle.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_push, i_din  : push request and byte
//   i_pop          : pop request (ignored while empty)
//   o_dout         : head byte, 0 while empty
//   o_full/o_empty : occupancy flags
//   o_count        : number of stored bytes
// -----------------------------------------------------------------------------
module tx_byte_fifo #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_push,
    input  logic [7:0]                  i_din,
    input  logic                        i_pop,
    output logic [7:0]                  o_dout,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [$clog2(FIFO_DEPTH):0] o_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_pop;
    logic w_push;

    assign o_full  = (r_count == CW'(FIFO_DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = o_empty ? 8'h00 : r_mem[r_rd_ptr];

    assign w_pop  = i_pop && !o_empty;
    assign w_push = i_push && (!o_full || w_pop);

    // Storage is not reset; an empty FIFO never exposes it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Data-memory port responder for the core: word RAM in region 0 plus an I/O
// page at 0xFFFF0000 (TXDATA, STATUS, TIMER, CMP). Loads are combinational,
// stores land on the next rising edge.
// Optional build macro: DATA_MEM_RESPONDER_TIMER_EN enables TIMER/CMP/MATCH;
// without it those registers read 0 and timer_irq is tied low.
// Ports:
//   clk, reset            : clock, asynchronous active-low reset
//   memwrite, addr        : store strobe, byte address
//   writedata, readdata   : store data, load data
//   tx_valid, tx_data     : FIFO head handshake towards the consumer
//   tx_ready              : consumer accepts the head byte
//   timer_irq             : STATUS.MATCH
// -----------------------------------------------------------------------------
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] addr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready,
    output logic        timer_irq
);

    localparam int RAM_AW = $clog2(DEPTH_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    sel_e              w_sel;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_wr_ram;
    logic              w_wr_txdata;
    logic              w_wr_status;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CNT_W-1:0]  w_count;
    logic [7:0]        w_dout;
    logic              w_ovf_set;
    logic              w_match;
    logic [31:0]       w_timer_rd;
    logic [31:0]       w_cmp_rd;
    logic [31:0]       w_status;
    logic              w_unused;

    logic [31:0]       r_ram [DEPTH_WORDS];
    logic              r_ovf;

    assign w_sel       = decode_addr(addr[31:2]);
    // Upper in-region bits above the index alias onto the same word.
    assign w_ram_idx   = addr[RAM_AW+1:2];
    assign w_wr_ram    = memwrite && (w_sel == SEL_RAM);
    assign w_wr_txdata = memwrite && (w_sel == SEL_TXDATA);
    assign w_wr_status = memwrite && (w_sel == SEL_STATUS);
    assign w_unused    = ^addr[1:0];

    assign tx_valid = !w_empty;
    assign tx_data  = w_dout;
    assign w_pop    = tx_valid && tx_ready;

    // Dropped byte: FIFO full and no pop freeing a slot this cycle.
    assign w_ovf_set = w_wr_txdata && w_full && !w_pop;

    tx_byte_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_push  (w_wr_txdata),
        .i_din   (writedata[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // RAM contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_ram) begin
            r_ram[w_ram_idx] <= writedata;
        end
    end

    // Sticky overflow; a set wins over a same-cycle W1C.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_ovf_set) begin
            r_ovf <= 1'b1;
        end else if (w_wr_status && writedata[STATUS_OVF]) begin
            r_ovf <= 1'b0;
        end
    end

`ifdef DATA_MEM_RESPONDER_TIMER_EN
    logic        w_wr_timer;
    logic        w_wr_cmp;
    logic [31:0] r_timer;
    logic [31:0] r_cmp;
    logic        r_match;

    assign w_wr_timer = memwrite && (w_sel == SEL_TIMER);
    assign w_wr_cmp   = memwrite && (w_sel == SEL_CMP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_timer <= 32'h0000_0000;
            r_cmp   <= 32'hFFFF_FFFF;
            r_match <= 1'b0;
        end else begin
            r_timer <= w_wr_timer ? writedata : r_timer + 32'd1;
            if (w_wr_cmp) begin
                r_cmp <= writedata;
            end
            // Compare uses the registered timer; a set wins over W1C.
            if (r_timer == r_cmp) begin
                r_match <= 1'b1;
            end else if (w_wr_status && writedata[STATUS_MATCH]) begin
                r_match <= 1'b0;
            end
        end
    end

    assign w_match    = r_match;
    assign w_timer_rd = r_timer;
    assign w_cmp_rd   = r_cmp;
`else
    assign w_match    = 1'b0;
    assign w_timer_rd = 32'h0000_0000;
    assign w_cmp_rd   = 32'h0000_0000;
`endif

    assign timer_irq = w_match;

    always_comb begin
        w_status                                     = '0;
        w_status[STATUS_FULL]                        = w_full;
        w_status[STATUS_EMPTY]                       = w_empty;
        w_status[STATUS_MATCH]                       = w_match;
        w_status[STATUS_OVF]                         = r_ovf;
        w_status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(w_count);
    end

    // Loads see the state before the pending edge.
    always_comb begin
        readdata = 32'h0000_0000;
        case (w_sel)
            SEL_RAM:    readdata = r_ram[w_ram_idx];
            SEL_STATUS: readdata = w_status;
            SEL_TIMER:  readdata = w_timer_rd;
            SEL_CMP:    readdata = w_cmp_rd;
            default:    readdata = 32'h0000_0000;
        endcase
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_data_mem_responder
// Directed bench: a table of single-cycle load/store vectors for the RAM and
// decode, followed by hand-written FIFO, timer and reset sequences. Timer
// expectations follow DATA_MEM_RESPONDER_TIMER_EN.
// -----------------------------------------------------------------------------
module tb_data_mem_responder;

    localparam logic [31:0] A_TX  = 32'hFFFF_0000;
    localparam logic [31:0] A_ST  = 32'hFFFF_0004;
    localparam logic [31:0] A_TM  = 32'hFFFF_0008;
    localparam logic [31:0] A_CMP = 32'hFFFF_000C;

`ifdef DATA_MEM_RESPONDER_TIMER_EN
    localparam logic [31:0] CMP_RST = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] CMP_RST = 32'h0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] writedata = 32'h0;
    logic [31:0] readdata;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready = 1'b0;
    logic        timer_irq;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        we;
        logic [31:0] a;
        logic [31:0] wd;
        logic        ck;
        logic [31:0] exp;
        string       nm;
    } vec_t;

    vec_t vecs[13];

    always #5 clk = ~clk;

    data_mem_responder #(
        .DEPTH_WORDS (64),
        .FIFO_DEPTH  (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .memwrite  (memwrite),
        .addr      (addr),
        .writedata (writedata),
        .readdata  (readdata),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready),
        .timer_irq (timer_irq)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; store lands on the next rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        memwrite  = 1'b1;
        addr      = a;
        writedata = d;
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    task automatic rd(input string name, input logic [31:0] a, input logic [31:0] exp);
        addr = a;
        #1;
        chk(name, readdata, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0,          "st_10"};
        vecs[1]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF,  "ld_10"};
        vecs[2]  = '{1'b0, 32'h0000_0012, 32'h0,         1'b1, 32'hDEAD_BEEF,  "ld_12"};
        vecs[3]  = '{1'b0, 32'h0000_0110, 32'h0,         1'b1, 32'hDEAD_BEEF,  "ld_alias_110"};
        vecs[4]  = '{1'b0, 32'h2000_0000, 32'h0,         1'b1, 32'h0,          "ld_unmapped"};
        vecs[5]  = '{1'b1, 32'h0000_0014, 32'h1234_5678, 1'b0, 32'h0,          "st_14"};
        vecs[6]  = '{1'b0, 32'h0000_0014, 32'h0,         1'b1, 32'h1234_5678,  "ld_14"};
        vecs[7]  = '{1'b0, 32'h0000_0010, 32'h0,         1'b1, 32'hDEAD_BEEF,  "ld_10_again"};
        vecs[8]  = '{1'b1, 32'h3000_0000, 32'h5555_5555, 1'b0, 32'h0,          "st_unmapped"};
        vecs[9]  = '{1'b0, 32'h3000_0000, 32'h0,         1'b1, 32'h0,          "ld_unmapped2"};
        vecs[10] = '{1'b0, 32'hFFFF_0010, 32'h0,         1'b1, 32'h0,          "ld_io_hole"};
        vecs[11] = '{1'b0, A_TX,          32'h0,         1'b1, 32'h0,          "ld_txdata"};
        vecs[12] = '{1'b0, A_ST,          32'h0,         1'b1, 32'h0000_0002,  "ld_status_idle"};

        // Reset state, observed while reset is held
        #12;
        chk("rst_tx_valid", 32'(tx_valid), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_irq", 32'(timer_irq), 32'h0);
        rd("rst_status", A_ST, 32'h0000_0002);
        rd("rst_timer", A_TM, 32'h0);
        rd("rst_cmp", A_CMP, CMP_RST);
        @(negedge clk);
        reset = 1'b1;
        step();

        // Table-driven RAM and decode vectors, one per cycle
        for (int i = 0; i < 13; i++) begin
            memwrite  = vecs[i].we;
            addr      = vecs[i].a;
            writedata = vecs[i].wd;
            #1;
            if (vecs[i].ck) chk(vecs[i].nm, readdata, vecs[i].exp);
            @(negedge clk);
            memwrite = 1'b0;
        end

        // Fill past capacity with the consumer stalled
        tx_ready = 1'b0;
        for (int i = 1; i <= 9; i++) wr(A_TX, 32'(i));
        rd("status_full_ovf", A_ST, 32'h0000_0089);
        chk("full_tx_valid", 32'(tx_valid), 32'h1);
        tx_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            #1;
            chk("drain_byte", 32'(tx_data), 32'(i));
            @(negedge clk);
        end
        tx_ready = 1'b0;
        #1;
        chk("drained_tx_valid", 32'(tx_valid), 32'h0);
        chk("drained_tx_data", 32'(tx_data), 32'h0);
        rd("status_empty_ovf", A_ST, 32'h0000_000A);
        wr(A_ST, 32'h0000_0008);
        rd("status_ovf_cleared", A_ST, 32'h0000_0002);

        // Push into a full FIFO while a pop frees the head slot
        for (int i = 0; i < 8; i++) wr(A_TX, 32'h10 + 32'(i));
        rd("status_full", A_ST, 32'h0000_0081);
        tx_ready = 1'b1;
        wr(A_TX, 32'h0000_00AA);
        tx_ready = 1'b0;
        rd("status_push_pop_full", A_ST, 32'h0000_0081);
        chk("head_after_pop", 32'(tx_data), 32'h11);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("drain2_byte", 32'(tx_data), (i < 7) ? 32'h11 + 32'(i) : 32'h0000_00AA);
            @(negedge clk);
        end
        tx_ready = 1'b0;
        #1;
        chk("drain2_tx_valid", 32'(tx_valid), 32'h0);

`ifdef DATA_MEM_RESPONDER_TIMER_EN
        // Wrap, compare and MATCH behaviour
        wr(A_TM, 32'hFFFF_FFFE);
        wr(A_CMP, 32'h0000_0001);
        rd("timer_ffffffff", A_TM, 32'hFFFF_FFFF);
        chk("irq_before", 32'(timer_irq), 32'h0);
        step();
        rd("timer_wrap0", A_TM, 32'h0);
        step();
        rd("timer_1", A_TM, 32'h1);
        chk("irq_at_equal", 32'(timer_irq), 32'h0);
        step();
        rd("timer_2", A_TM, 32'h2);
        chk("irq_rise", 32'(timer_irq), 32'h1);
        rd("status_match", A_ST, 32'h0000_0006);
        step();
        wr(A_ST, 32'h0000_0004);
        rd("status_match_clr", A_ST, 32'h0000_0002);
        chk("irq_cleared", 32'(timer_irq), 32'h0);
        rd("timer_4", A_TM, 32'h4);
        wr(A_CMP, 32'h0000_0007);
        rd("timer_5", A_TM, 32'h5);
        step();
        step();
        rd("timer_7", A_TM, 32'h7);
        wr(A_ST, 32'h0000_0004);
        chk("irq_set_wins", 32'(timer_irq), 32'h1);
        wr(A_ST, 32'h0000_0004);
        chk("irq_w1c", 32'(timer_irq), 32'h0);
`else
        // Timer absent: registers read 0, writes ignored
        wr(A_TM, 32'h0000_0005);
        rd("timer_off", A_TM, 32'h0);
        wr(A_CMP, 32'h0000_0007);
        rd("cmp_off", A_CMP, 32'h0);
        step();
        step();
        chk("irq_off", 32'(timer_irq), 32'h0);
        wr(A_ST, 32'h0000_0004);
        rd("status_no_match", A_ST, 32'h0000_0002);
`endif

        // Reset in the middle of a drain
        tx_ready = 1'b0;
        wr(A_TX, 32'h21);
        wr(A_TX, 32'h22);
        wr(A_TX, 32'h23);
        tx_ready = 1'b1;
        step();
        #1;
        chk("mid_drain_head", 32'(tx_data), 32'h22);
        #1;
        reset = 1'b0;
        #1;
        chk("async_tx_valid", 32'(tx_valid), 32'h0);
        chk("async_tx_data", 32'(tx_data), 32'h0);
        chk("async_irq", 32'(timer_irq), 32'h0);
        rd("rst2_timer", A_TM, 32'h0);
        rd("rst2_cmp", A_CMP, CMP_RST);
        rd("rst2_ram_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("rst2_status", A_ST, 32'h0000_0002);
        tx_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        rd("post_rst_status", A_ST, 32'h0000_0002);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Responder for the core's data-memory port: serves single-cycle loads and stores from the core (`memwrite`, address, `writedata`, `readdata`). Backs a word-addressed RAM plus a small memory-mapped I/O page. The page holds a byte transmit FIFO drained over valid/ready, a status register and a cycle timer with compare flag. Sits beside the core at top level, in place of a bare data RAM.

## Interface
- `DEPTH_WORDS`, 64: RAM size in 32-bit words, power of two.
- `FIFO_DEPTH`, 8: TX FIFO entries, power of two, 2..16.
- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `memwrite` in 1: store strobe from core.
- `addr` in 32: byte address (core ALU result); `addr[1:0]` ignored.
- `writedata` in 32: store data.
- `readdata` out 32: load data, combinational from `addr` and current state.
- `tx_valid` out 1: FIFO non-empty.
- `tx_data` out 8: FIFO head byte.
- `tx_ready` in 1: consumer accepts head this cycle.
- `timer_irq` out 1: equals STATUS.MATCH.

## Operation
- Decode:
  - RAM when `addr[31:28]==0`, word index `addr[log2(DEPTH_WORDS)+1:2]`; upper in-region bits alias.
  - I/O page at `0xFFFF0000`: TXDATA +0x0, STATUS +0x4, TIMER +0x8, CMP +0xC.
  - Any other address: reads return 0, writes ignored.
- RAM: write on edge when `memwrite` and decoded. Contents not reset.
- TXDATA:
  - Write pushes `writedata[7:0]`. Reads return 0.
  - Push accepted when count < FIFO_DEPTH, or when a pop occurs in the same cycle.
  - Otherwise the byte is dropped and sticky OVF is set.
- STATUS read:
  - bit0 FULL, bit1 EMPTY, bit2 MATCH, bit3 OVF, bits[8:4] count; other bits 0.
  - STATUS write is write-1-to-clear on bits 2 and 3; other bits are ignored.
- Pop:
  - Occurs when `tx_valid && tx_ready`.
  - `tx_data` is the head entry.
  - `tx_data` is 0 when empty.
- TIMER:
  - Increments by 1 every cycle, wrapping `0xFFFFFFFF` to 0.
  - A write loads `writedata` instead of incrementing that cycle.
- CMP: read/write register.
- MATCH:
  - Set on the edge where the registered TIMER value equals CMP.
  - A set and a W1C in the same cycle resolve to set.
- Same-cycle OVF set and W1C clear resolve to set.

## Timing
- Loads: zero latency; `readdata` reflects state before the pending edge. A read of STATUS in the same cycle as a push shows the pre-push count.
- Stores take effect at the next rising edge.
- Reset values:
  - `readdata` per decode of reset state.
  - `tx_valid` 0, `tx_data` 0, `timer_irq` 0.
  - FIFO empty; pointers 0.
  - TIMER 0, CMP `0xFFFFFFFF`, MATCH 0, OVF 0.
- Reset asserted mid-operation: FIFO contents discarded, with `tx_valid` falling asynchronously. RAM retains its contents.
- Push-to-`tx_valid`: 1 cycle, since the push is registered at the edge.
- Pop with `tx_ready` held high: one byte per cycle.
- Pointers wrap modulo FIFO_DEPTH. Count is a separate log2(FIFO_DEPTH)+1-bit register.

## Configuration
- `DATA_MEM_RESPONDER_TIMER_EN` defined:
  - TIMER, CMP and MATCH implemented as above.
  - `timer_irq` driven by MATCH.
- `DATA_MEM_RESPONDER_TIMER_EN` undefined:
  - No timer logic is built.
  - TIMER/CMP reads return 0 and their writes are ignored.
  - STATUS bit2 reads 0; `timer_irq` is tied 0.

## Structure
- Package `data_mem_responder_pkg` holds:
  - I/O base `0xFFFF0000` and register offsets.
  - STATUS bit indices (FULL, EMPTY, MATCH, OVF, COUNT_LSB).
  - RAM region tag.
- One sub-module `tx_byte_fifo`:
  - Parameter FIFO_DEPTH.
  - Ports: push/din, pop/dout, full, empty, count.
  - Implements the pop-frees-slot push rule.
- Top holds decode, RAM array, STATUS/OVF logic and the timer.

## Test plan
- Store `0xDEADBEEF` to `0x00000010`, then load `0x00000010` and `0x00000012` -> `readdata` `0xDEADBEEF` both; load `0x20000000` -> 0.
- With `tx_ready`=0, write TXDATA 9 times with bytes 1..9 -> STATUS FULL=1, count=8, OVF=1. Raise `tx_ready` -> bytes 1..8 on consecutive cycles; `tx_valid` then falls.
- With FIFO full and `tx_ready`=1, write byte `0xAA` -> push accepted, count stays 8, OVF stays 0.
- Write TIMER `0xFFFFFFFE` and CMP `0x00000001` -> TIMER reads `0xFFFFFFFF`, then 0, then 1. MATCH/`timer_irq` rise on the following edge. STATUS write `0x4` clears MATCH.
- Assert `reset` low mid-drain -> `tx_valid` 0 immediately, TIMER 0, CMP `0xFFFFFFFF`, RAM word at `0x10` retained.
- Build without `DATA_MEM_RESPONDER_TIMER_EN`, write TIMER `0x5` -> TIMER reads 0, `timer_irq` stays 0.
